uart_cmd_parser: RTL and testbench

Packet-level controller behind the serial receiver: consumes the received-byte stream (valid strobe plus byte) and sequences it into register-write commands for the synth control registers. A packet is a sync byte, an address byte, a 16-bit data word (MSB first) and an XOR checksum. Valid packets produce a single-cycle write strobe. Bad checksums and inter-byte stalls are discarded and flagged.

---
 rtl/uart_cmd_parser.sv | 109 ++++++++++
 tb/tb_uart_cmd_parser.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Sequences received UART bytes (sync, addr, data hi, data lo, xor checksum) into register writes.
// Outputs are registered one clock after the completing byte; inter-byte stalls abort the packet.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 160000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Wr_En,
  output logic [7:0]  o_Wr_Addr,
  output logic [15:0] o_Wr_Data,
  output logic        o_Err,
  output logic        o_Timeout,
  output logic [7:0]  o_Err_Count,
  output logic        o_Busy
);

  localparam int CW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK
  } state_t;

  state_t         state;
  logic [CW-1:0]  to_cnt;
  logic [7:0]     sh_addr;
  logic [15:0]    sh_data;
  logic [7:0]     err_inc;
  logic           csum_ok;

  assign err_inc = (o_Err_Count == 8'hFF) ? 8'hFF : o_Err_Count + 8'd1;
  assign csum_ok = (i_Rx_Byte == (sh_addr ^ sh_data[15:8] ^ sh_data[7:0]));

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      sh_addr     <= 8'h00;
      sh_data     <= 16'h0000;
      o_Wr_En     <= 1'b0;
      o_Wr_Addr   <= 8'h00;
      o_Wr_Data   <= 16'h0000;
      o_Err       <= 1'b0;
      o_Timeout   <= 1'b0;
      o_Err_Count <= 8'h00;
      o_Busy      <= 1'b0;
    end else begin
      o_Wr_En   <= 1'b0;
      o_Err     <= 1'b0;
      o_Timeout <= 1'b0;
      if (state == S_IDLE) begin
        to_cnt <= '0;
        if (i_Rx_DV && i_Rx_Byte == SYNC_BYTE) begin
          state  <= S_ADDR;
          o_Busy <= 1'b1;
        end
      end else if (i_Rx_DV) begin
        // A byte arriving on the last allowed cycle still wins over the timeout.
        to_cnt <= '0;
        case (state)
          S_ADDR: begin
            sh_addr <= i_Rx_Byte;
            state   <= S_DATA_HI;
          end
          S_DATA_HI: begin
            sh_data[15:8] <= i_Rx_Byte;
            state         <= S_DATA_LO;
          end
          S_DATA_LO: begin
            sh_data[7:0] <= i_Rx_Byte;
            state        <= S_CHECK;
          end
          S_CHECK: begin
            if (csum_ok) begin
              o_Wr_Addr <= sh_addr;
              o_Wr_Data <= sh_data;
              o_Wr_En   <= 1'b1;
            end else begin
              o_Err       <= 1'b1;
              o_Err_Count <= err_inc;
            end
            state  <= S_IDLE;
            o_Busy <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            o_Busy <= 1'b0;
          end
        endcase
      end else if (to_cnt == TO_LAST) begin
        o_Timeout   <= 1'b1;
        o_Err_Count <= err_inc;
        to_cnt      <= '0;
        state       <= S_IDLE;
        o_Busy      <= 1'b0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed packet stimulus checked every cycle against a packet-level model, plus literal pins.
module tb_uart_cmd_parser;

  localparam int T = 20;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv  = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        wr_en, err, tmo, busy;
  logic [7:0]  wr_addr, err_cnt;
  logic [15:0] wr_data;

  int vectors = 0;
  int miscompares = 0;

  uart_cmd_parser #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(T)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rx_byte),
    .o_Wr_En(wr_en), .o_Wr_Addr(wr_addr), .o_Wr_Data(wr_data),
    .o_Err(err), .o_Timeout(tmo), .o_Err_Count(err_cnt), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: bytes of the packet in flight plus idle cycles since the last accepted byte.
  logic [7:0]  pkt[$];
  int          gap = 0;
  logic        m_wr_en = 0, m_err = 0, m_tmo = 0, m_busy = 0;
  logic [7:0]  m_addr = 0;
  logic [15:0] m_data = 0;
  int          m_cnt = 0;

  function automatic int sat(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {wr_en, err, tmo, busy, wr_addr, wr_data, err_cnt} , 32'h0);
      pkt.delete();
      gap = 0;
      {m_wr_en, m_err, m_tmo, m_busy} = 4'b0;
      m_addr = 0; m_data = 0; m_cnt = 0;
    end else begin
      chk("wr_en", 32'(wr_en), 32'(m_wr_en));
      chk("err", 32'(err), 32'(m_err));
      chk("timeout", 32'(tmo), 32'(m_tmo));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("wr_addr", 32'(wr_addr), 32'(m_addr));
      chk("wr_data", 32'(wr_data), 32'(m_data));
      chk("err_count", 32'(err_cnt), 32'(m_cnt));
      m_wr_en = 0; m_err = 0; m_tmo = 0;
      if (pkt.size() == 0) begin
        gap = 0;
        if (dv && rx_byte == SYNC) pkt.push_back(rx_byte);
      end else if (dv) begin
        gap = 0;
        pkt.push_back(rx_byte);
        if (pkt.size() == 5) begin
          if ((pkt[1] ^ pkt[2] ^ pkt[3]) == pkt[4]) begin
            m_wr_en = 1; m_addr = pkt[1]; m_data = {pkt[2], pkt[3]};
          end else begin
            m_err = 1; m_cnt = sat(m_cnt);
          end
          pkt.delete();
        end
      end else begin
        gap++;
        if (gap == T) begin
          m_tmo = 1; m_cnt = sat(m_cnt);
          pkt.delete();
          gap = 0;
        end
      end
      m_busy = (pkt.size() != 0);
    end
  end

  task automatic send(input logic [7:0] b);
    dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    dv = 1'b0;
  endtask

  task automatic send5(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
    send(SYNC); send(a); send(h); send(l); send(c);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_err_count", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    idle(2);

    // Valid packet
    send5(8'h10, 8'h12, 8'h34, 8'h36);
    chk("pkt1_wr_en", 32'(wr_en), 32'h1);
    chk("pkt1_addr", 32'(wr_addr), 32'h10);
    chk("pkt1_data", 32'(wr_data), 32'h1234);
    chk("pkt1_errcnt", 32'(err_cnt), 32'h0);
    idle(1);
    chk("pkt1_wr_en_drop", 32'(wr_en), 32'h0);

    // Bad checksum
    send5(8'h10, 8'h12, 8'h34, 8'h37);
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_wr_en", 32'(wr_en), 32'h0);
    chk("bad_errcnt", 32'(err_cnt), 32'h1);
    chk("bad_data_held", 32'(wr_data), 32'h1234);
    idle(2);

    // Timeout after the address byte
    send(SYNC); send(8'h10);
    k = 0;
    for (int i = 1; i <= T + 5; i++) begin
      @(posedge clk); #1;
      if (tmo) begin k = i; break; end
    end
    chk("timeout_latency", 32'(k), 32'(T));
    chk("timeout_busy", 32'(busy), 32'h0);
    chk("timeout_errcnt", 32'(err_cnt), 32'h2);
    send5(8'h20, 8'h00, 8'h01, 8'h21);
    chk("post_to_addr", 32'(wr_addr), 32'h20);
    chk("post_to_data", 32'(wr_data), 32'h0001);
    idle(2);

    // Bytes landing on the last allowed cycle
    send(SYNC); send(8'h30);
    idle(T - 1);
    send(8'h40);
    idle(T - 1);
    send(8'h00);
    send(8'h70);
    chk("boundary_wr_en", 32'(wr_en), 32'h1);
    chk("boundary_data", 32'(wr_data), 32'h4000);
    chk("boundary_errcnt", 32'(err_cnt), 32'h2);
    idle(2);

    // Idle noise then sync byte used as address and checksum
    send(8'h00); send(8'hFF); send(8'h5A);
    send5(8'hA5, 8'h00, 8'h00, 8'hA5);
    chk("noise_addr", 32'(wr_addr), 32'hA5);
    chk("noise_data", 32'(wr_data), 32'h0000);
    chk("noise_errcnt", 32'(err_cnt), 32'h2);

    // Saturation
    for (int i = 0; i < 300; i++) send5(8'h01, 8'h02, 8'h03, 8'hFF);
    idle(1);
    chk("sat_errcnt", 32'(err_cnt), 32'hFF);

    // Reset mid-packet
    send(SYNC); send(8'h10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_errcnt", 32'(err_cnt), 32'h0);
    rst = 1'b0;
    idle(1);
    send5(8'h55, 8'hAA, 8'h01, 8'hFE);
    chk("after_rst_wr_en", 32'(wr_en), 32'h1);
    chk("after_rst_addr", 32'(wr_addr), 32'h55);
    chk("after_rst_data", 32'(wr_data), 32'hAA01);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
